// File: rtl/button_pkg.sv
// Shared definitions for the button_event block: FSM state encoding,
// default timing constants (25 MHz clock) and a counter-sizing helper.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam int DEF_REPEAT_DELAY  = 12500000;
    localparam int DEF_REPEAT_PERIOD = 2500000;
    localparam int DEF_LONG_LIMIT    = 25000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_event_edge.sv
// Edge_Detect: registers the previous switch sample and derives
// single-cycle rise/fall indications against the current sample.
module Edge_Detect
    import button_pkg::*;
(
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Rise,
    output logic o_Fall
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = i_Switch;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign o_Rise = i_Switch & ~prev_q;
    assign o_Fall = ~i_Switch & prev_q;

endmodule

// File: rtl/button_event.sv
// button_event: press/release/auto-repeat/long-press event generator.
// Auto-repeat exists only when BUTTON_EVENT_REPEAT_EN is defined.
module button_event
    import button_pkg::*;
#(
    parameter int C_REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int C_REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int C_LONG_LIMIT    = DEF_LONG_LIMIT
)
(
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Repeat,
    output logic o_Held,
    output logic o_Long
);

    localparam int CNT_W = $clog2(max3(C_REPEAT_DELAY, C_REPEAT_PERIOD, C_LONG_LIMIT) + 1);
    localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(C_LONG_LIMIT);

    logic rise;
    logic fall;

    Edge_Detect u_edge (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Switch (i_Switch),
        .o_Rise   (rise),
        .o_Fall   (fall)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] long_cnt_q, long_cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             held_q, held_d;
    logic             long_q, long_d;

    // Release (i_Switch low) wins over everything, so no event other than
    // o_Release can be generated in the cycle the release is sampled.
    always_comb begin
        press_d   = rise;
        release_d = fall;
        held_d    = i_Switch;
        long_cnt_d = long_cnt_q;
        if (!i_Switch) begin
            long_cnt_d = '0;
        end else if (long_cnt_q != LONG_LIM) begin
            long_cnt_d = long_cnt_q + 1'b1;
        end
        long_d = i_Switch & (long_cnt_d == LONG_LIM);
    end

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_TERM  = CNT_W'(C_REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_TERM = CNT_W'(C_REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             repeat_q, repeat_d;

    function automatic logic [CNT_W-1:0] term_of(input state_t s);
        return (s == REPEAT) ? PERIOD_TERM : DELAY_TERM;
    endfunction

    // The counter shows the terminal value in the same cycle o_Repeat pulses
    // and clears on the following edge.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        repeat_d  = 1'b0;
        if (!i_Switch) begin
            state_d   = IDLE;
            rep_cnt_d = '0;
        end else if (rise) begin
            state_d   = WAIT;
            rep_cnt_d = '0;
            repeat_d  = (DELAY_TERM == '0);
        end else begin
            if (rep_cnt_q == term_of(state_q)) begin
                state_d   = REPEAT;
                rep_cnt_d = '0;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
            repeat_d = (rep_cnt_d == term_of(state_d));
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rep_cnt_q <= '0;
            repeat_q  <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            repeat_q  <= repeat_d;
        end
    end

    assign o_Repeat = repeat_q;
`else
    always_comb begin
        state_d = i_Switch ? WAIT : IDLE;
    end

    assign o_Repeat = 1'b0;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= IDLE;
            long_cnt_q <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            held_q     <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            long_cnt_q <= long_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            held_q     <= held_d;
            long_q     <= long_d;
        end
    end

    assign o_Press   = press_q;
    assign o_Release = release_q;
    assign o_Held    = held_q;
    assign o_Long    = long_q;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event with short timing (delay 4, period 2, long 8):
// run-length event model plus directed literal checks.
module tb_button_event;

    localparam int D = 4;
    localparam int P = 2;
    localparam int L = 8;
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic REP_EN = 1'b1;
`else
    localparam logic REP_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic sw    = 1'b0;
    logic o_Press, o_Release, o_Repeat, o_Held, o_Long;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    button_event #(
        .C_REPEAT_DELAY  (D),
        .C_REPEAT_PERIOD (P),
        .C_LONG_LIMIT    (L)
    ) dut (
        .i_Clk     (clk),
        .i_Rst_L   (rst_n),
        .i_Switch  (sw),
        .o_Press   (o_Press),
        .o_Release (o_Release),
        .o_Repeat  (o_Repeat),
        .o_Held    (o_Held),
        .o_Long    (o_Long)
    );

    // Model: n = number of consecutive high samples so far (this one included).
    int   m_run   = 0;
    logic m_prev  = 1'b0;
    logic e_press = 1'b0, e_rel = 1'b0, e_rep = 1'b0, e_held = 1'b0, e_long = 1'b0;

    function automatic logic rep_due(input int n);
        if (!REP_EN) return 1'b0;
        if (n == D) return 1'b1;
        if (n > D && ((n - D) % P) == 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 0; m_prev <= 1'b0;
            e_press <= 1'b0; e_rel <= 1'b0; e_rep <= 1'b0; e_held <= 1'b0; e_long <= 1'b0;
        end else begin
            m_prev <= sw;
            if (sw) begin
                m_run   <= m_run + 1;
                e_press <= !m_prev;
                e_rel   <= 1'b0;
                e_held  <= 1'b1;
                e_long  <= (m_run + 1) >= L;
                e_rep   <= rep_due(m_run + 1);
            end else begin
                m_run   <= 0;
                e_press <= 1'b0;
                e_rel   <= m_prev;
                e_held  <= 1'b0;
                e_long  <= 1'b0;
                e_rep   <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_press",   o_Press,   e_press);
        chk("model_release", o_Release, e_rel);
        chk("model_repeat",  o_Repeat,  e_rep);
        chk("model_held",    o_Held,    e_held);
        chk("model_long",    o_Long,    e_long);
    end

    // Holds sw high for n samples, then low; returns just after the release edge.
    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); sw = 1'b1;
        end
        @(negedge clk); sw = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); sw = 1'b0;
        end
    endtask

    initial begin
        int lens[7] = '{1, 2, 7, 9, 10, 11, 20};

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_press", o_Press, 1'b0);
        chk("rst_release", o_Release, 1'b0);
        chk("rst_repeat", o_Repeat, 1'b0);
        chk("rst_held", o_Held, 1'b0);
        chk("rst_long", o_Long, 1'b0);
        rst_n = 1'b1;
        idle(1);

        // 12-cycle hold, then release
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk); sw = (c <= 12);
            @(posedge clk); #2;
            case (c)
                1:  begin chk("h12_press_c1", o_Press, 1'b1); chk("h12_held_c1", o_Held, 1'b1); end
                2:  chk("h12_press_c2", o_Press, 1'b0);
                3:  chk("h12_repeat_c3", o_Repeat, 1'b0);
                4:  chk("h12_repeat_c4", o_Repeat, REP_EN);
                5:  chk("h12_repeat_c5", o_Repeat, 1'b0);
                6:  chk("h12_repeat_c6", o_Repeat, REP_EN);
                7:  chk("h12_long_c7", o_Long, 1'b0);
                8:  begin chk("h12_long_c8", o_Long, 1'b1); chk("h12_repeat_c8", o_Repeat, REP_EN); end
                12: chk("h12_repeat_c12", o_Repeat, REP_EN);
                13: begin
                    chk("h12_release", o_Release, 1'b1);
                    chk("h12_held_off", o_Held, 1'b0);
                    chk("h12_long_off", o_Long, 1'b0);
                    chk("h12_repeat_rel", o_Repeat, 1'b0);
                end
                default: ;
            endcase
        end
        idle(3);

        hold(3);
        chk("h3_release", o_Release, 1'b1);
        chk("h3_repeat", o_Repeat, 1'b0);
        chk("h3_long", o_Long, 1'b0);
        idle(2);

        hold(4);
        chk("h4_release", o_Release, 1'b1);
        chk("h4_repeat", o_Repeat, 1'b0);
        idle(2);

        hold(5);
        chk("h5_release", o_Release, 1'b1);
        chk("h5_repeat", o_Repeat, 1'b0);
        idle(2);

        // reset in held cycle 6, switch stays high
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); sw = 1'b1;
        end
        @(posedge clk); #2;
        chk("rstmid_repeat_c6", o_Repeat, REP_EN);
        chk("rstmid_held_c6", o_Held, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_press", o_Press, 1'b0);
        chk("rstmid_release", o_Release, 1'b0);
        chk("rstmid_repeat", o_Repeat, 1'b0);
        chk("rstmid_held", o_Held, 1'b0);
        chk("rstmid_long", o_Long, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("rstrel_press", o_Press, 1'b1);
        chk("rstrel_release", o_Release, 1'b0);
        hold(2);
        chk("rstrel_final_release", o_Release, 1'b1);
        idle(2);

        // single-cycle press
        @(negedge clk); sw = 1'b1;
        @(posedge clk); #2;
        chk("one_press", o_Press, 1'b1);
        chk("one_held", o_Held, 1'b1);
        @(negedge clk); sw = 1'b0;
        @(posedge clk); #2;
        chk("one_release", o_Release, 1'b1);
        chk("one_press_off", o_Press, 1'b0);
        chk("one_held_off", o_Held, 1'b0);
        chk("one_repeat", o_Repeat, 1'b0);
        idle(2);

        foreach (lens[i]) begin
            hold(lens[i]);
            chk("tbl_release", o_Release, 1'b1);
            idle(2);
        end

        idle(3);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- C_REPEAT_DELAY, 12500000, cycles held before the first auto-repeat (500 ms at 25 MHz).
- C_REPEAT_PERIOD, 2500000, cycles between subsequent auto-repeats (100 ms).
- C_LONG_LIMIT, 25000000, cycles held before the long-press flag is raised (1 s).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_Clk, input, 1, single clock; all logic on the rising edge.
- i_Rst_L, input, 1, asynchronous active-low reset.
- i_Switch, input, 1, debounced button level, active-high, synchronous to i_Clk.
- o_Press, output, 1, one-cycle pulse on press.
- o_Release, output, 1, one-cycle pulse on release.
- o_Repeat, output, 1, one-cycle auto-repeat pulse while held.
- o_Held, output, 1, level; registered copy of the pressed state.
- o_Long, output, 1, level; high once held C_LONG_LIMIT cycles, until release.

Function
REQ-003 All outputs SHALL be registered; response latency is 1 cycle from the clock edge that samples the i_Switch change.
REQ-004 The rising edge (i_Switch=1, previous sample 0) SHALL assert o_Press for exactly one cycle and set o_Held.
REQ-005 The falling edge SHALL assert o_Release for exactly one cycle and clear o_Held, o_Long, all counters and state in the same edge.
REQ-006 The FSM SHALL have states IDLE, WAIT, REPEAT; IDLE->WAIT on rising edge; any state->IDLE on i_Switch=0.
REQ-007 In WAIT the repeat counter SHALL count from 0; at count C_REPEAT_DELAY-1, o_Repeat SHALL pulse, the counter SHALL clear, and the FSM SHALL move to REPEAT.
REQ-008 In REPEAT, o_Repeat SHALL pulse and the counter SHALL clear each time the count reaches C_REPEAT_PERIOD-1.
REQ-009 Release SHALL take priority: no o_Repeat in the cycle release is sampled, even at the terminal count.
REQ-010 A separate long counter SHALL count held cycles and saturate at C_LONG_LIMIT (no wrap), setting o_Long when it reaches the limit.
REQ-011 Counter widths SHALL be ceil(log2(max parameter + 1)), and all parameters SHALL be >= 1.
REQ-012 A press of one cycle SHALL produce o_Press then o_Release on consecutive cycles, with no o_Repeat.

Reset
REQ-013 Asserting i_Rst_L=0 SHALL immediately force all outputs to 0, the FSM to IDLE, counters to 0, and the previous sample to 0.
REQ-014 Reset mid-press SHALL abort the press with no o_Release; if i_Switch is high at reset release, o_Press SHALL fire on the first edge after reset release.

Configuration
REQ-015 Macro BUTTON_EVENT_REPEAT_EN defined: auto-repeat behaves per REQ-006..REQ-009.
REQ-016 Macro BUTTON_EVENT_REPEAT_EN undefined: the REPEAT state and repeat counter are absent, o_Repeat is tied to 0, the FSM remains in WAIT while held, and press, release and long-press behaviour is unchanged.

Structure
REQ-017 Shared package button_pkg SHALL hold the FSM state encodings (IDLE, WAIT, REPEAT) and the default timing constants.
REQ-018 The block SHALL instantiate one sub-module, Edge_Detect (registered previous sample, rise and fall pulses); the FSM and counters remain in button_event.

Verification (C_REPEAT_DELAY=4, C_REPEAT_PERIOD=2, C_LONG_LIMIT=8)
REQ-019 Hold i_Switch=1 for 12 cycles:
- o_Press at cycle 1.
- o_Repeat at cycles 4, 6, 8, 10, 12.
- o_Long high from cycle 8.
- o_Release 1 cycle after the fall.
REQ-020 Hold for 3 cycles -> o_Press and o_Release only; no o_Repeat; o_Long stays 0.
REQ-021 Release exactly at repeat terminal count (held 4 cycles) -> o_Release asserted; o_Repeat not asserted in that cycle.
REQ-022 Assert i_Rst_L=0 at held cycle 6 -> all outputs 0 asynchronously; no o_Release; with i_Switch still 1, o_Press fires 1 cycle after reset release.
REQ-023 Single-cycle press -> o_Press and o_Release on consecutive cycles; o_Held high for one cycle.
REQ-024 Build without BUTTON_EVENT_REPEAT_EN and hold 12 cycles -> o_Repeat constant 0; o_Press and o_Long timing identical to REQ-019.
